// File: rtl/num_joiner.sv
// Builds a binary number from BCD digits entered most-significant first.
// The committed value is published on numero with a one-cycle done pulse.
module num_joiner #(
    parameter int WIDTH      = 8,
    parameter int MAX_DIGITS = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [3:0]                           digit,
    input  logic                                 digit_valid,
    input  logic                                 commit,
    input  logic                                 clear,
    output logic [WIDTH-1:0]                     numero,
    output logic [WIDTH-1:0]                     acumulado,
    output logic [$clog2(MAX_DIGITS+1)-1:0]      digit_count,
    output logic                                 done,
    output logic                                 err_digit,
    output logic                                 overflow
);
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_DIGITS);

    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  acc_reg, acc_next;
    logic [WIDTH-1:0]  numero_reg, numero_next;
    logic [CW-1:0]     count_reg, count_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;
    logic              ovf_reg, ovf_next;

    // acc*10 + digit as two shifts; the width constraint on the
    // parameters guarantees the truncated result is exact.
    logic [WIDTH+3:0]  acc_wide;
    logic [WIDTH+3:0]  acc_x10;
    logic [CW-1:0]     count_inc;

    assign acc_wide  = {4'b0000, acc_reg};
    assign acc_x10   = (acc_wide << 3) + (acc_wide << 1) + {{WIDTH{1'b0}}, digit};
    assign count_inc = count_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= EMPTY;
            acc_reg    <= '0;
            numero_reg <= '0;
            count_reg  <= '0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            numero_reg <= numero_next;
            count_reg  <= count_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
            ovf_reg    <= ovf_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        numero_next = numero_reg;
        count_next  = count_reg;
        done_next   = 1'b0;
        err_next    = err_reg;
        ovf_next    = ovf_reg;

        // clear beats commit beats digit_valid; losers leave no trace
        if (clear) begin
            state_next = EMPTY;
            acc_next   = '0;
            count_next = '0;
            err_next   = 1'b0;
            ovf_next   = 1'b0;
        end else if (commit) begin
            if (state_reg != EMPTY) begin
                numero_next = acc_reg;
                done_next   = 1'b1;
                state_next  = EMPTY;
                acc_next    = '0;
                count_next  = '0;
                err_next    = 1'b0;
                ovf_next    = 1'b0;
            end
        end else if (digit_valid) begin
            if (digit > 4'd9) begin
                err_next = 1'b1;
            end else if (state_reg == FULL) begin
                ovf_next = 1'b1;
            end else begin
                acc_next   = acc_x10[WIDTH-1:0];
                count_next = count_inc;
                state_next = (count_inc == FULL_CNT) ? FULL : PARTIAL;
            end
        end
    end

    assign numero      = numero_reg;
    assign acumulado   = acc_reg;
    assign digit_count = count_reg;
    assign done        = done_reg;
    assign err_digit   = err_reg;
    assign overflow    = ovf_reg;
endmodule

// File: tb/tb_num_joiner.sv
// Self-checking bench for num_joiner: directed scenarios plus random strobes
// compared against an arithmetic model of the digit-entry rules.
module tb_num_joiner;
    localparam int WIDTH      = 8;
    localparam int MAX_DIGITS = 2;
    localparam int CW         = $clog2(MAX_DIGITS + 1);

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [3:0]        digit = 4'd0;
    logic              digit_valid = 1'b0;
    logic              commit = 1'b0;
    logic              clear = 1'b0;
    logic [WIDTH-1:0]  numero;
    logic [WIDTH-1:0]  acumulado;
    logic [CW-1:0]     digit_count;
    logic              done;
    logic              err_digit;
    logic              overflow;

    num_joiner #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) dut (
        .clk(clk), .reset(reset), .digit(digit), .digit_valid(digit_valid),
        .commit(commit), .clear(clear), .numero(numero), .acumulado(acumulado),
        .digit_count(digit_count), .done(done), .err_digit(err_digit),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int done_pulses = 0;

    // reference model state
    int m_num = 0, m_acc = 0, m_cnt = 0;
    bit m_done = 0, m_err = 0, m_ovf = 0;

    // Applies one clock of stimulus, then advances the model by the entry rules.
    task automatic drive(input bit rst, input bit clr, input bit cm, input bit dv, input int d);
        reset = rst; clear = clr; commit = cm; digit_valid = dv; digit = 4'(d);
        @(posedge clk);
        #1;
        reset = 0; clear = 0; commit = 0; digit_valid = 0;
        m_done = 0;
        if (rst) begin
            m_num = 0; m_acc = 0; m_cnt = 0; m_err = 0; m_ovf = 0;
        end else if (clr) begin
            m_acc = 0; m_cnt = 0; m_err = 0; m_ovf = 0;
        end else if (cm) begin
            if (m_cnt > 0) begin
                m_num = m_acc; m_done = 1;
                m_acc = 0; m_cnt = 0; m_err = 0; m_ovf = 0;
            end
        end else if (dv) begin
            if (d > 9)                    m_err = 1;
            else if (m_cnt == MAX_DIGITS) m_ovf = 1;
            else begin
                m_acc = m_acc * 10 + d;
                m_cnt = m_cnt + 1;
            end
        end
        if (done) done_pulses++;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0);
        total++;
        if (numero !== 0 || acumulado !== 0 || digit_count !== 0 ||
            done !== 0 || err_digit !== 0 || overflow !== 0) begin
            $display("FAIL reset: numero=%0d acc=%0d cnt=%0d done=%0b err=%0b ovf=%0b, required all 0",
                     numero, acumulado, digit_count, done, err_digit, overflow);
        end else passed++;
    endtask

    task automatic test_basic();
        drive(0, 0, 0, 1, 2);
        total++;
        if (acumulado !== WIDTH'(m_acc)) $display("FAIL basic_acc1: got %0d required %0d", acumulado, m_acc);
        else passed++;
        drive(0, 0, 0, 1, 5);
        total++;
        if (acumulado !== WIDTH'(m_acc) || digit_count !== CW'(m_cnt))
            $display("FAIL basic_acc2: got acc=%0d cnt=%0d required acc=%0d cnt=%0d", acumulado, digit_count, m_acc, m_cnt);
        else passed++;
        drive(0, 0, 1, 0, 0);
        total++;
        if (numero !== WIDTH'(m_num) || done !== m_done || digit_count !== 0)
            $display("FAIL basic_commit: got num=%0d done=%0b cnt=%0d required num=%0d done=%0b cnt=0",
                     numero, done, digit_count, m_num, m_done);
        else passed++;
        drive(0, 0, 0, 0, 0);
        total++;
        if (done !== 1'b0) $display("FAIL basic_done_width: got done=%0b required 0", done);
        else passed++;
    endtask

    task automatic test_leading_zero();
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 7);
        total++;
        if (acumulado !== WIDTH'(m_acc) || digit_count !== CW'(m_cnt))
            $display("FAIL lz_acc: got acc=%0d cnt=%0d required acc=%0d cnt=%0d", acumulado, digit_count, m_acc, m_cnt);
        else passed++;
        drive(0, 0, 1, 0, 0);
        total++;
        if (numero !== WIDTH'(m_num)) $display("FAIL lz_commit: got %0d required %0d", numero, m_num);
        else passed++;
        drive(0, 0, 0, 1, 4);
        drive(0, 0, 1, 0, 0);
        total++;
        if (numero !== WIDTH'(m_num) || done !== m_done)
            $display("FAIL single_digit: got num=%0d done=%0b required num=%0d done=%0b", numero, done, m_num, m_done);
        else passed++;
        drive(0, 0, 1, 0, 0);
        total++;
        if (numero !== WIDTH'(m_num) || done !== m_done)
            $display("FAIL empty_commit: got num=%0d done=%0b required num=%0d done=%0b", numero, done, m_num, m_done);
        else passed++;
    endtask

    task automatic test_overflow();
        drive(0, 0, 0, 1, 9);
        drive(0, 0, 0, 1, 9);
        drive(0, 0, 0, 1, 3);
        total++;
        if (acumulado !== WIDTH'(m_acc) || overflow !== m_ovf || err_digit !== m_err)
            $display("FAIL overflow_set: got acc=%0d ovf=%0b err=%0b required acc=%0d ovf=%0b err=%0b",
                     acumulado, overflow, err_digit, m_acc, m_ovf, m_err);
        else passed++;
        drive(0, 0, 1, 0, 0);
        total++;
        if (numero !== WIDTH'(m_num) || overflow !== m_ovf)
            $display("FAIL overflow_commit: got num=%0d ovf=%0b required num=%0d ovf=%0b", numero, overflow, m_num, m_ovf);
        else passed++;
    endtask

    task automatic test_invalid_digit();
        drive(0, 0, 0, 1, 1);
        drive(0, 0, 0, 1, 12);
        total++;
        if (err_digit !== m_err || acumulado !== WIDTH'(m_acc) || digit_count !== CW'(m_cnt))
            $display("FAIL invalid_set: got err=%0b acc=%0d cnt=%0d required err=%0b acc=%0d cnt=%0d",
                     err_digit, acumulado, digit_count, m_err, m_acc, m_cnt);
        else passed++;
        drive(0, 0, 0, 1, 3);
        drive(0, 0, 1, 0, 0);
        total++;
        if (numero !== WIDTH'(m_num) || err_digit !== m_err)
            $display("FAIL invalid_commit: got num=%0d err=%0b required num=%0d err=%0b", numero, err_digit, m_num, m_err);
        else passed++;
        // invalid digit while full raises err_digit only
        drive(0, 0, 0, 1, 5);
        drive(0, 0, 0, 1, 6);
        drive(0, 0, 0, 1, 15);
        total++;
        if (err_digit !== m_err || overflow !== m_ovf)
            $display("FAIL invalid_full: got err=%0b ovf=%0b required err=%0b ovf=%0b", err_digit, overflow, m_err, m_ovf);
        else passed++;
        drive(0, 1, 0, 0, 0);
    endtask

    task automatic test_priority_reset();
        drive(0, 0, 0, 1, 4);
        drive(0, 1, 1, 1, 6);
        total++;
        if (acumulado !== WIDTH'(m_acc) || done !== m_done || numero !== WIDTH'(m_num) || digit_count !== CW'(m_cnt))
            $display("FAIL priority: got acc=%0d done=%0b num=%0d cnt=%0d required acc=%0d done=%0b num=%0d cnt=%0d",
                     acumulado, done, numero, digit_count, m_acc, m_done, m_num, m_cnt);
        else passed++;
        drive(0, 0, 0, 1, 8);
        drive(1, 0, 0, 0, 0);
        total++;
        if (numero !== 0 || acumulado !== 0 || digit_count !== 0 ||
            done !== 0 || err_digit !== 0 || overflow !== 0)
            $display("FAIL mid_reset: numero=%0d acc=%0d cnt=%0d done=%0b err=%0b ovf=%0b, required all 0",
                     numero, acumulado, digit_count, done, err_digit, overflow);
        else passed++;
    endtask

    task automatic test_round_trip();
        int start_pulses;
        start_pulses = done_pulses;
        for (int n = 0; n < 100; n++) begin
            drive(0, 0, 0, 1, n / 10);
            drive(0, 0, 0, 1, n % 10);
            drive(0, 0, 1, 0, 0);
            total++;
            if (numero !== WIDTH'(n) || done !== 1'b1)
                $display("FAIL round_trip n=%0d: got num=%0d done=%0b required num=%0d done=1", n, numero, done, n);
            else passed++;
        end
        total++;
        if (done_pulses - start_pulses !== 100)
            $display("FAIL round_trip_pulses: got %0d required 100", done_pulses - start_pulses);
        else passed++;
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            drive(r == 0, r >= 1 && r < 6, r >= 4 && r < 20, r >= 15,
                  (r % 7 == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9)));
            total++;
            if (numero !== WIDTH'(m_num) || acumulado !== WIDTH'(m_acc) || digit_count !== CW'(m_cnt) ||
                done !== m_done || err_digit !== m_err || overflow !== m_ovf)
                $display("FAIL random i=%0d: got num=%0d acc=%0d cnt=%0d done=%0b err=%0b ovf=%0b required num=%0d acc=%0d cnt=%0d done=%0b err=%0b ovf=%0b",
                         i, numero, acumulado, digit_count, done, err_digit, overflow,
                         m_num, m_acc, m_cnt, m_done, m_err, m_ovf);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_leading_zero();
        test_overflow();
        test_invalid_digit();
        test_priority_reset();
        test_round_trip();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/num_joiner.md
Name: num_joiner

Overview:
- Inverse of the number separator: assembles a binary number from decimal digits entered one at a time, most-significant digit first.
- Typical sources are keypad or serial entry; the committed result drives the same display/compute paths that feed the separator.
- Accumulates value = value*10 + digit per accepted digit.
- Publishes the result on commit, with a one-cycle done strobe and sticky error/overflow flags.

Parameters:
- WIDTH, 8, bit width of the accumulator and result; must satisfy 10^MAX_DIGITS - 1 < 2^WIDTH.
- MAX_DIGITS, 2, maximum number of digits accepted per entry.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- digit  input  4  BCD digit; valid values 0..9.
- digit_valid  input  1  one-cycle strobe: offer digit this cycle.
- commit  input  1  one-cycle strobe: publish the accumulated value.
- clear  input  1  one-cycle strobe: discard the entry and clear flags.
- numero  output  WIDTH  last committed value.
- acumulado  output  WIDTH  running partial value, for live display.
- digit_count  output  $clog2(MAX_DIGITS+1)  digits accepted in the current entry.
- done  output  1  one-cycle pulse, the cycle after a successful commit.
- err_digit  output  1  sticky: an invalid digit (>9) was offered.
- overflow  output  1  sticky: a digit was offered while the entry was full.

Behaviour:
- Reset (reset=1 at a clock edge) has the highest priority and forces:
  - numero=0, acumulado=0, digit_count=0
  - done=0, err_digit=0, overflow=0
  - state=EMPTY
- Reset mid-entry discards the partial value; the previous numero is lost (forced to 0).
- States:
  - EMPTY: digit_count=0.
  - PARTIAL: 0 < digit_count < MAX_DIGITS.
  - FULL: digit_count = MAX_DIGITS.
- Priority among strobes in the same cycle: clear > commit > digit_valid. A lower-priority strobe is ignored completely and leaves no flag.
- clear, any state:
  - acumulado=0, digit_count=0, err_digit=0, overflow=0; next state EMPTY.
  - numero is unchanged; no done pulse.
- commit in PARTIAL or FULL:
  - numero <= acumulado; done=1 on the next cycle only.
  - acumulado=0, digit_count=0, both flags cleared; next state EMPTY.
- commit in EMPTY: ignored, with no done pulse and no change.
- digit_valid with digit <= 9 in EMPTY or PARTIAL:
  - acumulado <= acumulado*10 + digit, visible the cycle after the strobe.
  - digit_count increments; state advances EMPTY->PARTIAL, or PARTIAL->FULL when the count reaches MAX_DIGITS.
  - *10 is computed as (a<<3)+(a<<1) at WIDTH+4 bits, then truncated; the parameter constraint guarantees no loss.
- digit_valid with digit > 9, any state: the digit is rejected, err_digit <= 1, and acumulado, digit_count and state are unchanged.
- digit_valid with a valid digit in FULL: the digit is rejected, overflow <= 1, and the accumulator is unchanged.
- Both conditions at once: an invalid digit offered in FULL sets err_digit only.
- Leading zeros are accepted and counted: 0 then 7 gives acumulado=7 and digit_count=2.
- done is never held high for more than one cycle. Back-to-back commits produce one pulse, because the second commit sees EMPTY.
- Sticky flags stay set until clear, a successful commit, or reset.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Basic entry: reset, then digit 2 (valid), digit 5 (valid), commit.
  -> acumulado = 2, then 25; numero = 25 with done high exactly one cycle; digit_count returns to 0.
- Leading zero and single digit:
  - digits 0, 7, commit -> numero = 7.
  - then digit 4, commit -> numero = 4, done pulses again.
  - then a commit with no digits -> no done pulse, numero stays 4.
- Overflow: digits 9, 9, 3.
  -> acumulado stays 99 and overflow=1 after the third digit.
  -> commit gives numero=99 and overflow clears.
- Invalid digit: digit 1, digit 12, digit 3, commit.
  -> err_digit=1 after the 12; numero = 13; err_digit clears on the commit.
- Priority and reset: digit 4, then clear+commit+digit_valid(6) in the same cycle.
  -> acumulado = 0, no done pulse, numero unchanged.
  -> then digit 8 followed by reset -> every output is 0.
- Round trip: for N = 0..99, feed N's tens and units digits (from the separator) into the joiner and commit.
  -> numero == N for every N; done pulses 100 times.
